// File: rtl/bridge_buffer_ctrl.sv
// bridge_buffer_ctrl
//   Sequencer for one bank (west or north) of the bridge ping-pong buffer.
//   LOAD : takes TOTAL_DEPTH words from the linear projection and generates
//          the port-A write strobes and addresses.
//   READ : issues TOTAL_MODULES x TOTAL_DEPTH port-B reads toward the
//          systolic array, slice by slice. Each slice reads addresses
//          0..TOTAL_DEPTH-1.
//   Framing (out_valid, out_last, slicing_idx) is delayed one cycle from
//   the issue, which matches the fixed 1-cycle read latency of the bank.
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   start                     begins a load; acted on only in IDLE
//   in_valid / in_ready       upstream word handshake (LOAD only)
//   bank_ena/wea/addra        port-A write side
//   bank_enb/addrb            port-B read issue
//   out_ready                 downstream may take a word issued this cycle
//   out_valid/out_last        framing for the returned dout
//   slicing_idx               slice select for the returned dout
//   busy, done                sequence status; done is a 1-cycle pulse
module bridge_buffer_ctrl #(
  parameter int ADDR_WIDTH    = 8,
  parameter int TOTAL_DEPTH   = 12,
  parameter int TOTAL_MODULES = 4,
  localparam int SLW          = $clog2(TOTAL_MODULES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bank_ena,
  output logic                  bank_wea,
  output logic [ADDR_WIDTH-1:0] bank_addra,
  output logic                  bank_enb,
  output logic [ADDR_WIDTH-1:0] bank_addrb,
  output logic [SLW-1:0]        slicing_idx,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [SLW-1:0]        LAST_SLICE = SLW'(TOTAL_MODULES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [SLW-1:0]        rd_slice_q, rd_slice_d;
  logic [SLW-1:0]        slicing_idx_q, slicing_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  rd_at_end;

  // Strobes are combinational from state so a beat is never lost to a
  // register stage on either handshake.
  assign in_ready    = (state_q == LOAD);
  assign bank_ena    = in_ready & in_valid;
  assign bank_wea    = in_ready & in_valid;
  assign bank_addra  = wr_cnt_q;
  assign bank_enb    = (state_q == READ) & out_ready;
  assign bank_addrb  = rd_addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign slicing_idx = slicing_idx_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;

  assign rd_at_end   = (rd_addr_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_slice_d = rd_slice_q;
    // Read framing tracks the issue one cycle later; slicing_idx only
    // moves on an issue so it holds between sequences.
    out_valid_d   = bank_enb;
    out_last_d    = bank_enb & rd_at_end & (rd_slice_q == LAST_SLICE);
    slicing_idx_d = bank_enb ? rd_slice_q : slicing_idx_q;

    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (in_valid) begin
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d = '0;
            state_d  = READ;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      READ: begin
        if (bank_enb) begin
          if (rd_at_end) begin
            rd_addr_d = '0;
            if (rd_slice_q == LAST_SLICE) begin
              rd_slice_d = '0;
              state_d    = DRAIN;
            end else begin
              rd_slice_d = rd_slice_q + 1'b1;
            end
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      rd_addr_q     <= '0;
      rd_slice_q    <= '0;
      slicing_idx_q <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_addr_q     <= rd_addr_d;
      rd_slice_q    <= rd_slice_d;
      slicing_idx_q <= slicing_idx_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
    end
  end

endmodule

// File: tb/tb_bridge_buffer_ctrl.sv
// Directed bench for bridge_buffer_ctrl (D=12, M=4). Inputs change on the
// falling edge; outputs are checked 1ns later, away from the rising edge.
module tb_bridge_buffer_ctrl;
  localparam int D = 12;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic       in_ready, bank_ena, bank_wea, bank_enb;
  logic [7:0] bank_addra, bank_addrb;
  logic [1:0] slicing_idx;
  logic       out_valid, out_last, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  // read-side reference state
  int exp_addr, exp_slice, exp_sidx;
  bit prev_enb, prev_last;

  always #5 clk = ~clk;

  bridge_buffer_ctrl #(.ADDR_WIDTH(8), .TOTAL_DEPTH(D), .TOTAL_MODULES(M)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .bank_ena(bank_ena), .bank_wea(bank_wea), .bank_addra(bank_addra),
    .bank_enb(bank_enb), .bank_addrb(bank_addrb), .slicing_idx(slicing_idx),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".ena"},      bank_ena, 0);
    chk({tag, ".wea"},      bank_wea, 0);
    chk({tag, ".enb"},      bank_enb, 0);
    chk({tag, ".addra"},    bank_addra, 0);
    chk({tag, ".addrb"},    bank_addrb, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".out_last"}, out_last, 0);
    chk({tag, ".busy"},     busy, 0);
    chk({tag, ".done"},     done, 0);
  endtask

  // Pulse start for one cycle from IDLE.
  task automatic kick();
    @(negedge clk); start = 1'b1; #1;
    chk("kick.busy_before", busy, 0);
    @(negedge clk); start = 1'b0;
  endtask

  // LOAD: sparse=1 uses in_valid pattern 1,0,0,1,0,0,...
  task automatic load_phase(input bit sparse);
    int writes = 0;
    int cyc = 0;
    while (writes < D && cyc < 100) begin
      if (cyc != 0) @(negedge clk);
      in_valid  = sparse ? (cyc % 3 == 0) : 1'b1;
      out_ready = 1'b0;
      #1;
      chk("load.in_ready", in_ready, 1);
      chk("load.ena", bank_ena, in_valid);
      chk("load.wea", bank_wea, in_valid);
      chk("load.addra", bank_addra, writes);
      chk("load.enb", bank_enb, 0);
      if (in_valid) writes++;
      cyc++;
    end
    chk("load.write_count", writes, D);
    // first READ cycle, nothing issued yet
    @(negedge clk); in_valid = 1'b0; #1;
    chk("load.in_ready_drop", in_ready, 0);
    chk("load.wea_after", bank_wea, 0);
    chk("load.busy", busy, 1);
    exp_addr = 0; exp_slice = 0; prev_enb = 0; prev_last = 0;
  endtask

  // READ: stall=1 holds out_ready low 3 cycles after issue of (slice1,addr5).
  // abort_slice>=0 returns just before issuing (abort_slice, addr 3).
  task automatic read_phase(input bit stall, input int abort_slice);
    int issues = 0;
    int stall_cnt = 0;
    int cyc = 0;
    while (issues < D * M && cyc < 400) begin
      @(negedge clk);
      if (abort_slice >= 0 && exp_slice == abort_slice && exp_addr == 3) return;
      if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
      else out_ready = 1'b1;
      in_valid = stall;                       // stray in_valid must be ignored
      start    = (abort_slice >= 0 && cyc == 5); // start while busy
      #1;
      chk("read.enb", bank_enb, out_ready);
      chk("read.addrb", bank_addrb, exp_addr);
      chk("read.wea", bank_wea, 0);
      chk("read.ena", bank_ena, 0);
      chk("read.out_valid", out_valid, prev_enb);
      chk("read.out_last", out_last, prev_last);
      chk("read.slicing_idx", slicing_idx, exp_sidx);
      chk("read.done", done, 0);
      prev_enb  = out_ready;
      prev_last = 1'b0;
      if (out_ready) begin
        issues++;
        exp_sidx  = exp_slice;
        prev_last = (exp_slice == M - 1) && (exp_addr == D - 1);
        if (stall && exp_slice == 1 && exp_addr == 5) stall_cnt = 3;
        if (exp_addr == D - 1) begin exp_addr = 0; exp_slice++; end
        else exp_addr++;
      end
      cyc++;
    end
    chk("read.issue_count", issues, D * M);
    start = 1'b0; in_valid = 1'b0;
    // DRAIN
    @(negedge clk); out_ready = 1'b1; #1;
    chk("drain.enb", bank_enb, 0);
    chk("drain.out_valid", out_valid, 1);
    chk("drain.out_last", out_last, 1);
    chk("drain.slicing_idx", slicing_idx, M - 1);
    chk("drain.done", done, 0);
    chk("drain.busy", busy, 1);
    // DONE
    @(negedge clk); #1;
    chk("done.pulse", done, 1);
    chk("done.busy", busy, 1);
    chk("done.out_valid", out_valid, 0);
    chk("done.enb", bank_enb, 0);
    // back to IDLE
    @(negedge clk); out_ready = 1'b0; #1;
    chk("idle.done", done, 0);
    chk("idle.busy", busy, 0);
    chk("idle.slicing_idx_hold", slicing_idx, M - 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_sidx = 0;
    // 1: reset, then quiet idle with start low
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk_idle_outputs("reset");
    chk("reset.slicing_idx", slicing_idx, 0);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("idle.wea", bank_wea, 0);
      chk("idle.enb", bank_enb, 0);
      chk("idle.busy", busy, 0);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // 2 + 4: dense load, full-rate read
    kick();
    load_phase(1'b0);
    read_phase(1'b0, -1);

    // 3 + 5: sparse load, read with a 3-cycle stall after (slice1, addr5)
    kick();
    load_phase(1'b1);
    read_phase(1'b1, -1);

    // 6: reset mid-READ at slice 2, start pulsed while busy
    kick();
    load_phase(1'b0);
    read_phase(1'b0, 2);
    chk("abort.busy_before_rst", busy, 1);
    rst = 1'b1; out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk_idle_outputs("abort");
    chk("abort.slicing_idx", slicing_idx, 0);
    exp_sidx = 0;
    kick();
    load_phase(1'b0);
    read_phase(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
